// File: rtl/chk_pkg.sv
// chk_pkg: shared FSM encoding and elaboration helpers for the register file checker
package chk_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/reg_file_checker_if.sv
// reg_file_checker_if: synchronous register file read port between checker and core
interface reg_file_checker_if #(parameter int NUM_REGS = 32, parameter int DATA_WIDTH = 32);
  localparam int IDX_W = chk_pkg::clog2(NUM_REGS);
  logic                  rf_rd_en;
  logic [IDX_W-1:0]      rf_rd_index;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  modport master(output rf_rd_en, rf_rd_index, input rf_rd_data);
  modport slave(input rf_rd_en, rf_rd_index, output rf_rd_data);
endinterface

// File: rtl/chk_expect_store.sv
// chk_expect_store: expected value plus care bit per register, one write and one combinational read port
module chk_expect_store #(
  parameter int NUM_REGS = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      w_index,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_care,
  input  logic [IDX_W-1:0]      r_index,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_care
);
  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [NUM_REGS-1:0]   care_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) data_q[i] <= '0;
      care_q <= '1;
    end else if (we) begin
      data_q[w_index] <= w_data;
      care_q[w_index] <= w_care;
    end
  assign r_data = data_q[r_index];
  assign r_care = care_q[r_index];
endmodule

// File: rtl/reg_file_checker.sv
// reg_file_checker: waits for halt or timeout, scans the core register file and compares against expected values
module reg_file_checker import chk_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 100,
  parameter int CNT_W = 16,
  localparam int IDX_W = clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_index,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_care,
  input  logic                  start,
  input  logic                  halt,
  reg_file_checker_if.master    rf,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic                  timed_out,
  output logic [IDX_W:0]        mismatch_count,
  output logic [IDX_W-1:0]      first_fail_index,
  output logic [DATA_WIDTH-1:0] first_fail_actual
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  cmp_valid;
  logic [IDX_W-1:0]      cmp_idx;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  care_q;
  logic                  mm;
  logic [IDX_W:0]        mm_next;
  assign busy = state == S_WAIT || state == S_SCAN;
  assign done = state == S_DONE;
  assign mm = cmp_valid && care_q && rf.rf_rd_data != exp_q;
  assign mm_next = mismatch_count + {{IDX_W{1'b0}}, mm};
  chk_expect_store #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_store (
    .clock(clock), .reset(reset), .we(exp_we && !busy), .w_index(exp_index), .w_data(exp_data),
    .w_care(exp_care), .r_index(cmp_idx), .r_data(exp_q), .r_care(care_q)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      cmp_valid <= 1'b0;
      cmp_idx <= '0;
      rf.rf_rd_en <= 1'b0;
      rf.rf_rd_index <= '0;
      passed <= 1'b0;
      timed_out <= 1'b0;
      mismatch_count <= '0;
      first_fail_index <= '0;
      first_fail_actual <= '0;
    end else begin
      cmp_valid <= rf.rf_rd_en;
      cmp_idx <= rf.rf_rd_index;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state <= S_WAIT;
          cnt <= '0;
          passed <= 1'b0;
          timed_out <= 1'b0;
          mismatch_count <= '0;
          first_fail_index <= '0;
          first_fail_actual <= '0;
        end
        S_WAIT: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (halt || (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1))) begin
            state <= S_SCAN;
            timed_out <= !halt;
            rf.rf_rd_en <= 1'b1;
            rf.rf_rd_index <= '0;
          end
        end
        S_SCAN: begin
          if (rf.rf_rd_en) begin
            if (rf.rf_rd_index == LAST) rf.rf_rd_en <= 1'b0;
            else rf.rf_rd_index <= rf.rf_rd_index + IDX_W'(1);
          end
          // an empty count means this is the first failing register
          if (mm) begin
            mismatch_count <= mm_next;
            if (mismatch_count == '0) begin
              first_fail_index <= cmp_idx;
              first_fail_actual <= rf.rf_rd_data;
            end
          end
          if (cmp_valid && cmp_idx == LAST) begin
            state <= S_DONE;
            passed <= mm_next == '0 && !timed_out;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_file_checker.sv
// tb_reg_file_checker: directed vectors against a register file model with hand-computed results
module tb_reg_file_checker;
  localparam int N = 32;
  logic        clock = 0, reset = 0, exp_we = 0, exp_care = 0, start = 0, halt = 0;
  logic [4:0]  exp_index = 0;
  logic [31:0] exp_data = 0;
  logic        busy, done, passed, timed_out;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_fail_index;
  logic [31:0] first_fail_actual;
  logic [31:0] rf_model [N];
  logic [31:0] base [8] = '{32'h1, 32'h3, 32'h80000000, 32'h7ffff000, 32'hc0000000, 32'hf0000000, 32'h3ffff800, 32'h0ffffe00};
  int n_cmp = 0, n_bad = 0;
  reg_file_checker_if #(.NUM_REGS(N), .DATA_WIDTH(32)) rf();
  reg_file_checker #(.NUM_REGS(N), .DATA_WIDTH(32), .TIMEOUT(100), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .exp_we(exp_we), .exp_index(exp_index), .exp_data(exp_data),
    .exp_care(exp_care), .start(start), .halt(halt), .rf(rf.master), .busy(busy), .done(done),
    .passed(passed), .timed_out(timed_out), .mismatch_count(mismatch_count),
    .first_fail_index(first_fail_index), .first_fail_actual(first_fail_actual)
  );
  always #5 clock = ~clock;
  always @(posedge clock) rf.rf_rd_data <= rf_model[rf.rf_rd_index];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic load(input int i, input logic [31:0] d, input logic c);
    exp_we = 1; exp_index = 5'(i); exp_data = d; exp_care = c;
    @(negedge clock);
    exp_we = 0;
  endtask
  task automatic load_base();
    for (int i = 0; i < N; i++) begin
      rf_model[i] = (i >= 10 && i < 18) ? base[i-10] : 32'h0;
      load(i, rf_model[i], 1'b1);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk({tag, " done"}, done, 1);
  endtask
  task automatic run(input string tag, input int h);
    pulse_start();
    repeat (h) @(negedge clock);
    halt = 1;
    @(negedge clock);
    halt = 0;
    wait_done(tag);
  endtask
  task automatic results(input string tag, input int mm, input int ffi, input logic [31:0] ffa, input logic p, input logic to);
    chk({tag, " mismatch_count"}, mismatch_count, 64'(mm));
    chk({tag, " first_fail_index"}, first_fail_index, 64'(ffi));
    chk({tag, " first_fail_actual"}, first_fail_actual, ffa);
    chk({tag, " passed"}, passed, p);
    chk({tag, " timed_out"}, timed_out, to);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rf_rd_en"}, rf.rf_rd_en, 0);
    chk({tag, " rf_rd_index"}, rf.rf_rd_index, 0);
    results(tag, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int k;
    int hits [N];
    int bad_hits;
    for (int i = 0; i < N; i++) rf_model[i] = 0;
    repeat (2) @(negedge clock);
    all_zero("reset");
    reset = 1;
    @(negedge clock);
    load_base();
    run("t1", 19);
    results("t1", 0, 0, 0, 1, 0);
    rf_model[13] = 32'h7ffff001;
    rf_model[16] = 32'h0;
    run("t2", 5);
    results("t2", 2, 13, 32'h7ffff001, 0, 0);
    load(13, 32'h7ffff000, 1'b0);
    run("t3", 5);
    results("t3", 1, 16, 32'h0, 0, 0);
    load(13, 32'h7ffff000, 1'b1);
    rf_model[13] = 32'h7ffff000;
    rf_model[16] = 32'h3ffff800;
    pulse_start();
    k = 0;
    while (!rf.rf_rd_en && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("t4 wait cycles", 64'(k), 100);
    wait_done("t4");
    results("t4", 0, 0, 0, 0, 1);
    pulse_start();
    repeat (99) @(negedge clock);
    halt = 1;
    @(negedge clock);
    halt = 0;
    wait_done("t4b");
    results("t4b", 0, 0, 0, 1, 0);
    pulse_start();
    halt = 1;
    @(negedge clock);
    halt = 0;
    k = 0;
    while (!(rf.rf_rd_en && rf.rf_rd_index == 5'd9) && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("t5 reach index 9", rf.rf_rd_index, 9);
    #2 reset = 0;
    #1 all_zero("t5 async reset");
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    for (int i = 0; i < N; i++) hits[i] = 0;
    pulse_start();
    halt = 1;
    @(negedge clock);
    halt = 0;
    k = 0;
    if (rf.rf_rd_en) hits[rf.rf_rd_index]++;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
      if (rf.rf_rd_en) hits[rf.rf_rd_index]++;
    end
    chk("t5 halt to done", 64'(k), N + 1);
    bad_hits = 0;
    for (int i = 0; i < N; i++) if (hits[i] != 1) bad_hits++;
    chk("t5 index coverage", 64'(bad_hits), 0);
    results("t5 store reset", 8, 10, 32'h1, 0, 0);
    load_base();
    rf_model[5] = 32'h55;
    pulse_start();
    start = 1; exp_we = 1; exp_index = 5; exp_data = 32'h55; exp_care = 1;
    @(negedge clock);
    start = 0; exp_we = 0;
    repeat (3) @(negedge clock);
    halt = 1;
    @(negedge clock);
    halt = 0;
    start = 1; exp_we = 1;
    @(negedge clock);
    start = 0; exp_we = 0;
    wait_done("t6");
    results("t6", 1, 5, 32'h55, 0, 0);
    pulse_start();
    chk("t6 rearm busy", busy, 1);
    chk("t6 rearm done", done, 0);
    results("t6 rearm", 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
